// File: rtl/memtest_pkg.sv
// memtest_pkg: shared state and mode types for the march-style memory test engine.
package memtest_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_PAT,
    ST_RD1_REQ,
    ST_RD1_WAIT,
    ST_WR_ANTI,
    ST_RD2_REQ,
    ST_RD2_WAIT,
    ST_DONE
  } state_t;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_WALK  = 1'b1
  } mode_t;

endpackage

// File: rtl/memtest_pattern_gen.sv
// memtest_pattern_gen: per-word test pattern, either a fixed value or a walking one
// that restarts at bit 0 on load and rotates left on each advance.
module memtest_pattern_gen
  import memtest_pkg::*;
#(
  parameter int DATUM_WIDTH = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   load,
  input  logic                   advance,
  input  logic                   mode,
  input  logic [DATUM_WIDTH-1:0] fixed_pat,
  output logic [DATUM_WIDTH-1:0] pat
);

  localparam logic [DATUM_WIDTH-1:0] WALK_SEED = DATUM_WIDTH'(1);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      pat <= '0;
    end else if (load) begin
      pat <= (mode_t'(mode) == MODE_WALK) ? WALK_SEED : fixed_pat;
    end else if (advance && (mode_t'(mode) == MODE_WALK)) begin
      pat <= {pat[DATUM_WIDTH-2:0], pat[DATUM_WIDTH-1]};
    end
  end

endmodule

// File: rtl/memtest_march_engine.sv
// memtest_march_engine: three-pass pattern/antipattern memory test with its own address,
// data and compare path. Define MEMTEST_ERR_COUNT_EN to count miscompares instead of aborting.
module memtest_march_engine
  import memtest_pkg::*;
#(
  parameter int DATUM_WIDTH   = 8,
  parameter int ADDR_WIDTH    = 16,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  input  logic                     i_mode,
  input  logic [ADDR_WIDTH-1:0]    i_base_addr,
  input  logic [ADDR_WIDTH-1:0]    i_nwords,
  input  logic [DATUM_WIDTH-1:0]   i_pattern,
  output logic [ADDR_WIDTH-1:0]    o_mem_addr,
  output logic [DATUM_WIDTH-1:0]   o_mem_wdata,
  output logic                     o_mem_wr_valid,
  input  logic                     i_mem_wr_ready,
  output logic                     o_mem_rd_valid,
  input  logic                     i_mem_rd_ready,
  input  logic                     i_mem_rdata_valid,
  input  logic [DATUM_WIDTH-1:0]   i_mem_rdata,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_error,
  output logic [ADDR_WIDTH-1:0]    o_err_addr,
  output logic [DATUM_WIDTH-1:0]   o_err_expected,
  output logic [DATUM_WIDTH-1:0]   o_err_actual,
  output logic [ERR_CNT_WIDTH-1:0] o_err_count
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
`ifdef MEMTEST_ERR_COUNT_EN
  localparam bit ABORT_ON_ERR = 1'b0;
`else
  localparam bit ABORT_ON_ERR = 1'b1;
`endif

  state_t                 state_q;
  mode_t                  mode_q;
  logic [DATUM_WIDTH-1:0] pattern_q, pat, exp_data, gen_fixed;
  logic [ADDR_WIDTH-1:0]  base_q, nwords_q, offset_q;
  logic                   wr_hs, rd_hs, last_word, cmp_en, miscmp;
  logic                   pg_load, pg_advance, gen_mode;

  assign wr_hs     = o_mem_wr_valid & i_mem_wr_ready;
  assign rd_hs     = o_mem_rd_valid & i_mem_rd_ready;
  assign last_word = (offset_q == nwords_q - ADDR_ONE);
  assign exp_data  = (state_q == ST_RD2_WAIT) ? ~pat : pat;
  assign cmp_en    = i_mem_rdata_valid & ((state_q == ST_RD1_WAIT) | (state_q == ST_RD2_WAIT));
  assign miscmp    = cmp_en & (i_mem_rdata != exp_data);

  // The start-cycle load must see the live inputs; later pass loads use the latched copies.
  assign gen_mode  = (state_q == ST_IDLE) ? i_mode : logic'(mode_q);
  assign gen_fixed = (state_q == ST_IDLE) ? i_pattern : pattern_q;

  always_comb begin
    pg_load    = 1'b0;
    pg_advance = 1'b0;
    case (state_q)
      ST_IDLE: pg_load = i_start;
      ST_WR_PAT, ST_WR_ANTI: begin
        pg_load    = wr_hs & last_word;
        pg_advance = wr_hs & ~last_word;
      end
      ST_RD2_WAIT: pg_advance = cmp_en;
      default: ;
    endcase
  end

  memtest_pattern_gen #(
    .DATUM_WIDTH(DATUM_WIDTH)
  ) u_pattern_gen (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .load     (pg_load),
    .advance  (pg_advance),
    .mode     (gen_mode),
    .fixed_pat(gen_fixed),
    .pat      (pat)
  );

  always_comb begin
    case (state_q)
      ST_WR_PAT:  o_mem_wdata = pat;
      ST_WR_ANTI: o_mem_wdata = ~pat;
      default:    o_mem_wdata = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q        <= ST_IDLE;
      mode_q         <= MODE_FIXED;
      pattern_q      <= '0;
      base_q         <= '0;
      nwords_q       <= '0;
      offset_q       <= '0;
      o_mem_addr     <= '0;
      o_mem_wr_valid <= 1'b0;
      o_mem_rd_valid <= 1'b0;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
      o_error        <= 1'b0;
      o_err_addr     <= '0;
      o_err_expected <= '0;
      o_err_actual   <= '0;
    end else begin
      o_done <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            base_q         <= i_base_addr;
            nwords_q       <= i_nwords;
            mode_q         <= mode_t'(i_mode);
            pattern_q      <= i_pattern;
            offset_q       <= '0;
            o_mem_addr     <= i_base_addr;
            o_error        <= 1'b0;
            o_err_addr     <= '0;
            o_err_expected <= '0;
            o_err_actual   <= '0;
            if (i_nwords == '0) begin
              state_q <= ST_DONE;
              o_done  <= 1'b1;
            end else begin
              state_q        <= ST_WR_PAT;
              o_busy         <= 1'b1;
              o_mem_wr_valid <= 1'b1;
            end
          end
        end
        ST_WR_PAT: begin
          if (wr_hs) begin
            if (last_word) begin
              offset_q       <= '0;
              o_mem_addr     <= base_q;
              o_mem_wr_valid <= 1'b0;
              o_mem_rd_valid <= 1'b1;
              state_q        <= ST_RD1_REQ;
            end else begin
              offset_q   <= offset_q + ADDR_ONE;
              o_mem_addr <= o_mem_addr + ADDR_ONE;
            end
          end
        end
        ST_RD1_REQ, ST_RD2_REQ: begin
          if (rd_hs) begin
            o_mem_rd_valid <= 1'b0;
            state_q        <= (state_q == ST_RD1_REQ) ? ST_RD1_WAIT : ST_RD2_WAIT;
          end
        end
        ST_RD1_WAIT: begin
          if (cmp_en) begin
            if (miscmp && ABORT_ON_ERR) begin
              state_q <= ST_DONE;
              o_done  <= 1'b1;
              o_busy  <= 1'b0;
            end else begin
              state_q        <= ST_WR_ANTI;
              o_mem_wr_valid <= 1'b1;
            end
          end
        end
        ST_WR_ANTI: begin
          if (wr_hs) begin
            o_mem_wr_valid <= 1'b0;
            o_mem_rd_valid <= 1'b1;
            if (last_word) begin
              offset_q   <= '0;
              o_mem_addr <= base_q;
              state_q    <= ST_RD2_REQ;
            end else begin
              offset_q   <= offset_q + ADDR_ONE;
              o_mem_addr <= o_mem_addr + ADDR_ONE;
              state_q    <= ST_RD1_REQ;
            end
          end
        end
        ST_RD2_WAIT: begin
          if (cmp_en) begin
            if ((miscmp && ABORT_ON_ERR) || last_word) begin
              state_q <= ST_DONE;
              o_done  <= 1'b1;
              o_busy  <= 1'b0;
            end else begin
              offset_q       <= offset_q + ADDR_ONE;
              o_mem_addr     <= o_mem_addr + ADDR_ONE;
              o_mem_rd_valid <= 1'b1;
              state_q        <= ST_RD2_REQ;
            end
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase

      // Only the first miscompare of a run is kept; the flag stays until the next start.
      if (miscmp) begin
        o_error <= 1'b1;
        if (!o_error) begin
          o_err_addr     <= o_mem_addr;
          o_err_expected <= exp_data;
          o_err_actual   <= i_mem_rdata;
        end
      end
    end
  end

`ifdef MEMTEST_ERR_COUNT_EN
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_err_count <= '0;
    end else if ((state_q == ST_IDLE) && i_start) begin
      o_err_count <= '0;
    end else if (miscmp && (o_err_count != {ERR_CNT_WIDTH{1'b1}})) begin
      o_err_count <= o_err_count + ERR_CNT_WIDTH'(1);
    end
  end
`else
  assign o_err_count = '0;
`endif

endmodule
